// File: rtl/rv32i_pipe_top.sv
// Five-stage pipelined RV32I core (IF, ID, EX, MEM, WB) with operand forwarding,
// load-use stalling and branch/jump resolution in EX.

module Rv32iImem #(
    parameter int WORDS = 1024
) (
    input  logic [$clog2(WORDS)-1:0] wordAddr_i,
    output logic [31:0]              data_o
);
    logic [31:0] mem [0:WORDS-1];

    assign data_o = mem[wordAddr_i];
endmodule

module Rv32iRegFile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1Addr_i,
    input  logic [4:0]  rs2Addr_i,
    output logic [31:0] rs1Data_o,
    output logic [31:0] rs2Data_o,
    input  logic        we_i,
    input  logic [4:0]  rdAddr_i,
    input  logic [31:0] rdData_i
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we_i && (rdAddr_i != 5'd0)) begin
            regs[rdAddr_i] <= rdData_i;
        end
    end

    // A write landing this cycle is visible to the reader in ID immediately.
    always_comb begin
        rs1Data_o = regs[rs1Addr_i];
        rs2Data_o = regs[rs2Addr_i];
        if (we_i && (rdAddr_i == rs1Addr_i)) rs1Data_o = rdData_i;
        if (we_i && (rdAddr_i == rs2Addr_i)) rs2Data_o = rdData_i;
        if (rs1Addr_i == 5'd0) rs1Data_o = '0;
        if (rs2Addr_i == 5'd0) rs2Data_o = '0;
    end
endmodule

module Rv32iDmem #(
    parameter int WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] wordAddr_i,
    input  logic [3:0]               wstrb_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem[wordAddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem[wordAddr_i];
endmodule

module rv32i_pipe_top #(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input logic clk,
    input logic rst_n
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    typedef enum logic [3:0] {
        CL_NOP, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR,
        CL_BRANCH, CL_LOAD, CL_STORE, CL_OPIMM, CL_OP
    } instClass_e;

    // An all-zero value of any pipeline register is a bubble.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifId_t;

    typedef struct packed {
        instClass_e  cls;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        alt;
        logic        regWrite;
    } idEx_t;

    typedef struct packed {
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] storeData;
    } exMem_t;

    typedef struct packed {
        logic        regWrite;
        logic [4:0]  rd;
        logic [31:0] wbData;
    } memWb_t;

    logic [31:0] pc_q, pc_d;
    ifId_t       ifId_q, ifId_d;
    idEx_t       idEx_q, idEx_d;
    exMem_t      exMem_q, exMem_d;
    memWb_t      memWb_q, memWb_d;

    logic [31:0] imemData;
    Rv32iImem #(.WORDS(IMEM_WORDS)) INST1 (
        .wordAddr_i (pc_q[IAW+1:2]),
        .data_o     (imemData)
    );

    logic [31:0] idInstr, idImm, rfRs1Data, rfRs2Data;
    logic [6:0]  idOpcode, idFunct7;
    logic [2:0]  idFunct3;
    logic [4:0]  idRs1, idRs2, idRd;
    instClass_e  idCls;
    logic        idRegWrite, idAlt, loadUse;

    assign idInstr  = ifId_q.instr;
    assign idOpcode = idInstr[6:0];
    assign idRd     = idInstr[11:7];
    assign idFunct3 = idInstr[14:12];
    assign idRs1    = idInstr[19:15];
    assign idRs2    = idInstr[24:20];
    assign idFunct7 = idInstr[31:25];

    Rv32iRegFile RF1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1Addr_i (idRs1),
        .rs2Addr_i (idRs2),
        .rs1Data_o (rfRs1Data),
        .rs2Data_o (rfRs2Data),
        .we_i      (memWb_q.regWrite),
        .rdAddr_i  (memWb_q.rd),
        .rdData_i  (memWb_q.wbData)
    );

    // Unrecognised encodings, including FENCE/SYSTEM, fall through as NOPs.
    always_comb begin
        idCls = CL_NOP;
        case (idOpcode)
            7'b0110111: idCls = CL_LUI;
            7'b0010111: idCls = CL_AUIPC;
            7'b1101111: idCls = CL_JAL;
            7'b1100111: if (idFunct3 == 3'b000) idCls = CL_JALR;
            7'b1100011: if (idFunct3[2:1] != 2'b01) idCls = CL_BRANCH;
            7'b0000011: if (idFunct3 != 3'b011 && idFunct3[2:1] != 2'b11) idCls = CL_LOAD;
            7'b0100011: if (!idFunct3[2] && idFunct3 != 3'b011) idCls = CL_STORE;
            7'b0010011: idCls = CL_OPIMM;
            7'b0110011: if (idFunct7 == 7'b0000000 ||
                            (idFunct7 == 7'b0100000 && (idFunct3 == 3'b000 || idFunct3 == 3'b101)))
                            idCls = CL_OP;
            default:    idCls = CL_NOP;
        endcase

        case (idCls)
            CL_LUI, CL_AUIPC: idImm = {idInstr[31:12], 12'b0};
            CL_JAL:    idImm = {{11{idInstr[31]}}, idInstr[31], idInstr[19:12], idInstr[20], idInstr[30:21], 1'b0};
            CL_BRANCH: idImm = {{19{idInstr[31]}}, idInstr[31], idInstr[7], idInstr[30:25], idInstr[11:8], 1'b0};
            CL_STORE:  idImm = {{20{idInstr[31]}}, idInstr[31:25], idInstr[11:7]};
            default:   idImm = {{20{idInstr[31]}}, idInstr[31:20]};
        endcase
    end

    assign idRegWrite = (idCls == CL_LUI) || (idCls == CL_AUIPC) || (idCls == CL_JAL) ||
                        (idCls == CL_JALR) || (idCls == CL_LOAD) || (idCls == CL_OPIMM) ||
                        (idCls == CL_OP);
    assign idAlt   = idInstr[30] & ((idCls == CL_OP) | (idFunct3 == 3'b101));
    assign loadUse = (idEx_q.cls == CL_LOAD) && (idEx_q.rd != 5'd0) &&
                     ((idEx_q.rd == idRs1) || (idEx_q.rd == idRs2));

    logic [31:0] fwdA, fwdB, opB, aluRes, exAddr, exPcImm, exResult, exTarget;
    logic [4:0]  shamt;
    logic        brTaken, exRedirect;

    // EX/MEM is the younger producer, so it outranks MEM/WB.
    always_comb begin
        fwdA = idEx_q.rs1Val;
        fwdB = idEx_q.rs2Val;
        if (exMem_q.regWrite && exMem_q.rd != 5'd0 && exMem_q.rd == idEx_q.rs1)
            fwdA = exMem_q.result;
        else if (memWb_q.regWrite && memWb_q.rd != 5'd0 && memWb_q.rd == idEx_q.rs1)
            fwdA = memWb_q.wbData;
        if (exMem_q.regWrite && exMem_q.rd != 5'd0 && exMem_q.rd == idEx_q.rs2)
            fwdB = exMem_q.result;
        else if (memWb_q.regWrite && memWb_q.rd != 5'd0 && memWb_q.rd == idEx_q.rs2)
            fwdB = memWb_q.wbData;
    end

    assign opB     = (idEx_q.cls == CL_OP) ? fwdB : idEx_q.imm;
    assign shamt   = opB[4:0];
    assign exAddr  = fwdA + idEx_q.imm;
    assign exPcImm = idEx_q.pc + idEx_q.imm;

    always_comb begin
        case (idEx_q.funct3)
            3'b000:  aluRes = idEx_q.alt ? fwdA - opB : fwdA + opB;
            3'b001:  aluRes = fwdA << shamt;
            3'b010:  aluRes = {31'b0, $signed(fwdA) < $signed(opB)};
            3'b011:  aluRes = {31'b0, fwdA < opB};
            3'b100:  aluRes = fwdA ^ opB;
            3'b101:  aluRes = idEx_q.alt ? $unsigned($signed(fwdA) >>> shamt) : fwdA >> shamt;
            3'b110:  aluRes = fwdA | opB;
            default: aluRes = fwdA & opB;
        endcase

        case (idEx_q.funct3)
            3'b000:  brTaken = (fwdA == fwdB);
            3'b001:  brTaken = (fwdA != fwdB);
            3'b100:  brTaken = ($signed(fwdA) < $signed(fwdB));
            3'b101:  brTaken = ($signed(fwdA) >= $signed(fwdB));
            3'b110:  brTaken = (fwdA < fwdB);
            3'b111:  brTaken = (fwdA >= fwdB);
            default: brTaken = 1'b0;
        endcase

        case (idEx_q.cls)
            CL_LUI:            exResult = idEx_q.imm;
            CL_AUIPC:          exResult = exPcImm;
            CL_JAL, CL_JALR:   exResult = idEx_q.pc + 32'd4;
            CL_LOAD, CL_STORE: exResult = exAddr;
            CL_OPIMM, CL_OP:   exResult = aluRes;
            default:           exResult = '0;
        endcase
    end

    assign exRedirect = (idEx_q.cls == CL_JAL) || (idEx_q.cls == CL_JALR) ||
                        ((idEx_q.cls == CL_BRANCH) && brTaken);
    assign exTarget   = (idEx_q.cls == CL_JALR) ? {exAddr[31:1], 1'b0} : exPcImm;

    logic [1:0]  byteOff;
    logic [3:0]  baseStrb;
    logic [31:0] dmemRdata, loadShift, loadVal;

    assign byteOff = exMem_q.result[1:0];
    assign baseStrb = (exMem_q.funct3[1:0] == 2'b00) ? 4'b0001 :
                      (exMem_q.funct3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;

    Rv32iDmem #(.WORDS(DMEM_WORDS)) DATA1 (
        .clk        (clk),
        .we_i       (exMem_q.memWrite),
        .wordAddr_i (exMem_q.result[DAW+1:2]),
        .wstrb_i    (baseStrb << byteOff),
        .wdata_i    (exMem_q.storeData << {byteOff, 3'b000}),
        .rdata_o    (dmemRdata)
    );

    assign loadShift = dmemRdata >> {byteOff, 3'b000};

    always_comb begin
        case (exMem_q.funct3)
            3'b000:  loadVal = {{24{loadShift[7]}}, loadShift[7:0]};
            3'b001:  loadVal = {{16{loadShift[15]}}, loadShift[15:0]};
            3'b100:  loadVal = {24'b0, loadShift[7:0]};
            3'b101:  loadVal = {16'b0, loadShift[15:0]};
            default: loadVal = loadShift;
        endcase
    end

    // A taken redirect in EX overrides a simultaneous load-use stall.
    always_comb begin
        pc_d   = pc_q + 32'd4;
        ifId_d = '{pc: pc_q, instr: imemData};

        idEx_d          = '0;
        idEx_d.cls      = idCls;
        idEx_d.pc       = ifId_q.pc;
        idEx_d.imm      = idImm;
        idEx_d.rs1Val   = rfRs1Data;
        idEx_d.rs2Val   = rfRs2Data;
        idEx_d.rs1      = idRs1;
        idEx_d.rs2      = idRs2;
        idEx_d.rd       = idRd;
        idEx_d.funct3   = idFunct3;
        idEx_d.alt      = idAlt;
        idEx_d.regWrite = idRegWrite;

        if (exRedirect) begin
            pc_d   = exTarget;
            ifId_d = '0;
            idEx_d = '0;
        end else if (loadUse) begin
            pc_d   = pc_q;
            ifId_d = ifId_q;
            idEx_d = '0;
        end

        exMem_d.regWrite  = idEx_q.regWrite;
        exMem_d.memRead   = (idEx_q.cls == CL_LOAD);
        exMem_d.memWrite  = (idEx_q.cls == CL_STORE);
        exMem_d.funct3    = idEx_q.funct3;
        exMem_d.rd        = idEx_q.rd;
        exMem_d.result    = exResult;
        exMem_d.storeData = fwdB;

        memWb_d.regWrite = exMem_q.regWrite;
        memWb_d.rd       = exMem_q.rd;
        memWb_d.wbData   = exMem_q.memRead ? loadVal : exMem_q.result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            ifId_q  <= '0;
            idEx_q  <= '0;
            exMem_q <= '0;
            memWb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifId_q  <= ifId_d;
            idEx_q  <= idEx_d;
            exMem_q <= exMem_d;
            memWb_q <= memWb_d;
        end
    end
endmodule

// File: tb/tb_rv32i_pipe_top.sv
// Directed-program bench: every register write-back is checked against a
// queue of expected {rd, value, commit edge}, plus final architectural state.

module tb_rv32i_pipe_top;
    logic clk;
    logic rst_n;

    int testCount = 0;
    int failCount = 0;
    int edgeCount = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] edgeNo;
    } wbExp_t;

    wbExp_t      expQ[$];
    wbExp_t      monAct, monExp;
    logic [31:0] prog [0:7];

    rv32i_pipe_top #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge n after reset release is the edge at which a commit becomes architectural.
    always @(posedge clk) begin
        if (rst_n) edgeCount++;
    end

    // Monitor: every register write presented to RF1 consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && dut.RF1.we_i && dut.RF1.rdAddr_i != 5'd0) begin
            monAct.rd     = dut.RF1.rdAddr_i;
            monAct.data   = dut.RF1.rdData_i;
            monAct.edgeNo = edgeCount + 1;
            testCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpected_wb actual x%0d=%h @edge %0d required none",
                         monAct.rd, monAct.data, monAct.edgeNo);
            end else begin
                monExp = expQ.pop_front();
                if (monAct !== monExp) begin
                    failCount++;
                    $display("[TB] FAIL writeback actual x%0d=%h @edge %0d required x%0d=%h @edge %0d",
                             monAct.rd, monAct.data, monAct.edgeNo,
                             monExp.rd, monExp.data, monExp.edgeNo);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expectWb(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] edgeNo);
        wbExp_t e;
        e.rd     = rd;
        e.data   = data;
        e.edgeNo = edgeNo;
        expQ.push_back(e);
    endtask

    function automatic int nonzeroRegs();
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (dut.RF1.regs[i] != 32'd0) n++;
        end
        return n;
    endfunction

    task automatic loadProgram(input int len);
        for (int i = 0; i < 1024; i++) dut.INST1.mem[i] = 32'h0000_0013;
        for (int i = 0; i < len; i++) dut.INST1.mem[i] = prog[i];
    endtask

    // Hold reset 20 ns while loading the program, release on a falling edge, run.
    task automatic applyStimulus(input int len, input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        loadProgram(len);
        #20;
        @(negedge clk);
        edgeCount = 0;
        rst_n = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #20;
        checkOutput("reset_pc", dut.pc_q, 32'd0);
        checkOutput("reset_regs_nonzero", nonzeroRegs(), 32'd0);

        // Load-use: addi x1,x0,5; sw x1,0(x0); lw x2,0(x0); add x3,x2,x2
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0010_2023;
        prog[2] = 32'h0000_2103;
        prog[3] = 32'h0021_01B3;
        expectWb(5'd1, 32'd5, 5);
        expectWb(5'd2, 32'd5, 7);
        expectWb(5'd3, 32'd10, 9);
        applyStimulus(4, 20);
        checkOutput("loaduse_pending", expQ.size(), 32'd0);
        checkOutput("loaduse_x3", dut.RF1.regs[3], 32'd10);
        checkOutput("loaduse_mem0", dut.DATA1.mem[0], 32'd5);

        // Forwarding, interrupted by an asynchronous reset and rerun from address 0
        prog[0] = 32'h0030_0093;
        prog[1] = 32'h0040_8113;
        prog[2] = 32'h0011_01B3;
        expectWb(5'd1, 32'd3, 5);
        expectWb(5'd2, 32'd7, 6);
        @(negedge clk);
        rst_n = 1'b0;
        loadProgram(3);
        #20;
        @(negedge clk);
        edgeCount = 0;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_pending", expQ.size(), 32'd0);
        checkOutput("midrun_reset_pc", dut.pc_q, 32'd0);
        checkOutput("midrun_reset_regs_nonzero", nonzeroRegs(), 32'd0);
        expectWb(5'd1, 32'd3, 5);
        expectWb(5'd2, 32'd7, 6);
        expectWb(5'd3, 32'd10, 7);
        #16;
        @(negedge clk);
        edgeCount = 0;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("fwd_pending", expQ.size(), 32'd0);
        checkOutput("fwd_x2", dut.RF1.regs[2], 32'd7);
        checkOutput("fwd_x3", dut.RF1.regs[3], 32'd10);

        // Branch flush: addi x1,x0,1; beq x1,x1,+12; addi x5/x6 (skipped); addi x7,x0,2
        prog[0] = 32'h0010_0093;
        prog[1] = 32'h0010_8663;
        prog[2] = 32'h0090_0293;
        prog[3] = 32'h0090_0313;
        prog[4] = 32'h0020_0393;
        expectWb(5'd1, 32'd1, 5);
        expectWb(5'd7, 32'd2, 9);
        applyStimulus(5, 20);
        checkOutput("branch_pending", expQ.size(), 32'd0);
        checkOutput("branch_x5", dut.RF1.regs[5], 32'd0);
        checkOutput("branch_x6", dut.RF1.regs[6], 32'd0);
        checkOutput("branch_x7", dut.RF1.regs[7], 32'd2);

        // Jumps: jal x1,+8; (skip); addi x1,x0,0x11; jalr x2,4(x1); (skip); addi x7; auipc x8,0
        prog[0] = 32'h0080_00EF;
        prog[1] = 32'h0090_0293;
        prog[2] = 32'h0110_0093;
        prog[3] = 32'h0040_8167;
        prog[4] = 32'h0090_0313;
        prog[5] = 32'h0020_0393;
        prog[6] = 32'h0000_0417;
        expectWb(5'd1, 32'd4, 5);
        expectWb(5'd1, 32'h11, 8);
        expectWb(5'd2, 32'd16, 9);
        expectWb(5'd7, 32'd2, 12);
        expectWb(5'd8, 32'h18, 13);
        applyStimulus(7, 24);
        checkOutput("jump_pending", expQ.size(), 32'd0);
        checkOutput("jump_x5", dut.RF1.regs[5], 32'd0);
        checkOutput("jump_x6", dut.RF1.regs[6], 32'd0);
        checkOutput("jump_x8", dut.RF1.regs[8], 32'h18);

        // Sub-word: addi x1,x0,-1; sb x1,3(x0); lbu x2,3(x0); lb x3,3(x0); addi x0,x0,7
        prog[0] = 32'hFFF0_0093;
        prog[1] = 32'h0010_01A3;
        prog[2] = 32'h0030_4103;
        prog[3] = 32'h0030_0183;
        prog[4] = 32'h0070_0013;
        expectWb(5'd1, 32'hFFFF_FFFF, 5);
        expectWb(5'd2, 32'h0000_00FF, 7);
        expectWb(5'd3, 32'hFFFF_FFFF, 8);
        applyStimulus(5, 20);
        checkOutput("subword_pending", expQ.size(), 32'd0);
        checkOutput("subword_x0", dut.RF1.regs[0], 32'd0);
        checkOutput("subword_x2", dut.RF1.regs[2], 32'h0000_00FF);
        checkOutput("subword_x3", dut.RF1.regs[3], 32'hFFFF_FFFF);
        checkOutput("subword_mem0", dut.DATA1.mem[0], 32'hFF00_0005);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
